// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared constants and state type for the A2D SPI responder
package a2d_pkg;

  localparam int FRM_BITS = 16;
  localparam int CH_MSB   = 13;
  localparam int CH_LSB   = 11;
  localparam int PAD_W    = 4;
  localparam int SMPL_W   = FRM_BITS - PAD_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } resp_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchronizer with rise/fall pulses on the synced level
module spi_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  // N must be at least 2; the last stage feeds the edge detector
  logic [N-1:0] sr;
  logic         prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= {N{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[N-2:0], d};
      prev <= sr[N-1];
    end
  end

  assign rise = sr[N-1] & ~prev;
  assign fall = ~sr[N-1] & prev;

endmodule

// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - A2D converter end of the SPI link: decodes a channel
// command per frame and returns the previously requested sample on the next frame
module a2d_spi_resp #(
  parameter int FRM_BITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [11:0]         smpl_data,
  output logic                smpl_req,
  output logic [2:0]          smpl_ch,
  output logic [FRM_BITS-1:0] cmd,
  output logic                cmd_vld,
  output logic                frm_err
);

  import a2d_pkg::*;

  localparam int                CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] FRM_CNT = CNT_W'(FRM_BITS);

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   mosi_sync;

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // MOSI only needs to be stable at SCLK rise; same depth keeps it aligned with SCLK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];

  resp_state_t           state, state_nxt;
  logic [FRM_BITS-1:0]   tx_shft, rx_shft;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  first_fall;
  logic [11:0]           result;
  logic                  load_tx, frame_ok, frame_bad, do_rx, do_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_tx   = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    do_rx     = 1'b0;
    do_tx     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
          load_tx   = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          frame_ok  = (bit_cnt == FRM_CNT);
          frame_bad = (bit_cnt != FRM_CNT);
        end else begin
          do_rx = sclk_rise;
          do_tx = sclk_fall;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft    <= '0;
      rx_shft    <= '0;
      bit_cnt    <= '0;
      first_fall <= 1'b0;
      result     <= '0;
      cmd        <= '0;
      cmd_vld    <= 1'b0;
      frm_err    <= 1'b0;
      smpl_req   <= 1'b0;
      smpl_ch    <= '0;
    end else begin
      cmd_vld  <= frame_ok;
      frm_err  <= frame_bad;
      smpl_req <= cmd_vld;

      if (load_tx) begin
        tx_shft    <= FRM_BITS'(result);
        bit_cnt    <= '0;
        first_fall <= 1'b1;
      end

      if (do_rx) begin
        rx_shft <= {rx_shft[FRM_BITS-2:0], mosi_sync};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
      end

      // The master's first falling edge precedes any sampling, so MSB stays put
      if (do_tx) begin
        if (first_fall) first_fall <= 1'b0;
        else            tx_shft    <= {tx_shft[FRM_BITS-2:0], 1'b0};
      end

      if (frame_ok) begin
        cmd     <= rx_shft;
        smpl_ch <= rx_shft[CH_MSB:CH_LSB];
      end

      if (smpl_req) result <= smpl_data;
    end
  end

  assign MISO = (state == SHIFT) ? tx_shft[FRM_BITS-1] : 1'b0;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb/tb_a2d_spi_resp.sv - directed SPI-master bench for a2d_spi_resp
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] smpl_data;
  logic        smpl_req;
  logic [2:0]  smpl_ch;
  logic [15:0] cmd;
  logic        cmd_vld;
  logic        frm_err;
  logic        abc_mode;

  int n_vec  = 0;
  int n_miss = 0;
  int n_vld  = 0;
  int n_req  = 0;
  int n_err  = 0;

  localparam int HALF = 8;

  always #5 clk = ~clk;

  // Converter sample source: fixed 0xABC, or 0x100*ch + 5
  assign smpl_data = abc_mode ? 12'hABC : {1'b0, smpl_ch, 8'h05};

  a2d_spi_resp #(.FRM_BITS(16), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .smpl_data(smpl_data),
    .smpl_req (smpl_req),
    .smpl_ch  (smpl_ch),
    .cmd      (cmd),
    .cmd_vld  (cmd_vld),
    .frm_err  (frm_err)
  );

  always @(posedge clk) begin
    if (cmd_vld)  n_vld <= n_vld + 1;
    if (smpl_req) n_req <= n_req + 1;
    if (frm_err)  n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  // Mode-3 master: drive MOSI on SCLK fall, sample MISO just before SCLK rise
  task automatic spi_frame(input logic [15:0] word, input int nbits,
                           output logic [15:0] rdata, output logic vld3,
                           output logic err3, output logic req4);
    logic [15:0] w;
    w     = word;
    rdata = '0;
    SS_n  = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = w[15];
      w    = w << 1;
      wait_clks(HALF);
      rdata = {rdata[14:0], MISO};
      SCLK  = 1'b1;
      wait_clks(HALF);
    end
    SS_n = 1'b1;
    wait_clks(3);
    vld3 = cmd_vld;
    err3 = frm_err;
    wait_clks(1);
    req4 = smpl_req;
    wait_clks(12);
  endtask

  logic [15:0] rd;
  logic        v3, e3, r4;
  int          v0, r0, e0;
  logic [15:0] cmd0;
  logic [2:0]  chs  [4] = '{3'd0, 3'd3, 3'd7, 3'd0};
  logic [15:0] exps [4] = '{16'h0000, 16'h0005, 16'h0305, 16'h0705};

  initial begin
    abc_mode = 1'b1;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wait_clks(4);
    chk("rst_miso", MISO, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_vld", cmd_vld, 0);
    chk("rst_smpl_req", smpl_req, 0);
    chk("rst_smpl_ch", smpl_ch, 0);
    chk("rst_frm_err", frm_err, 0);
    rst_n = 1'b1;
    wait_clks(4);

    spi_frame(16'h2800, 16, rd, v3, e3, r4);
    chk("f1_miso", rd, 16'h0000);
    chk("f1_vld_lat", v3, 1);
    chk("f1_req_lat", r4, 1);
    chk("f1_err", e3, 0);
    chk("f1_cmd", cmd, 16'h2800);
    chk("f1_ch", smpl_ch, 5);
    spi_frame(16'h0000, 16, rd, v3, e3, r4);
    chk("f2_miso", rd, 16'h0ABC);

    abc_mode = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      spi_frame({2'b00, chs[k], 11'h000}, 16, rd, v3, e3, r4);
      chk($sformatf("b2b%0d_miso", k), rd, exps[k]);
      chk($sformatf("b2b%0d_ch", k), smpl_ch, chs[k]);
    end

    v0 = n_vld; r0 = n_req; e0 = n_err;
    spi_frame(16'h3800, 10, rd, v3, e3, r4);
    chk("short_err", e3, 1);
    chk("short_err_cnt", n_err - e0, 1);
    chk("short_no_vld", n_vld - v0, 0);
    chk("short_no_req", n_req - r0, 0);
    chk("short_cmd", cmd, 16'h0000);
    chk("short_ch", smpl_ch, 0);
    spi_frame(16'h1800, 16, rd, v3, e3, r4);
    chk("after_short_miso", rd, 16'h0005);
    chk("after_short_cmd", cmd, 16'h1800);

    v0 = n_vld;
    spi_frame(16'h3800, 17, rd, v3, e3, r4);
    chk("long_err", e3, 1);
    chk("long_no_vld", n_vld - v0, 0);
    chk("long_cmd", cmd, 16'h1800);
    chk("long_ch", smpl_ch, 3);

    SS_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; wait_clks(HALF);
      SCLK = 1'b1; wait_clks(HALF);
    end
    SCLK = 1'b0;
    wait_clks(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", MISO, 0);
    chk("midrst_cmd", cmd, 0);
    chk("midrst_ch", smpl_ch, 0);
    wait_clks(2);
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    spi_frame(16'h3800, 16, rd, v3, e3, r4);
    chk("postrst_miso", rd, 16'h0000);
    chk("postrst_cmd", cmd, 16'h3800);
    chk("postrst_ch", smpl_ch, 7);
    spi_frame(16'h0000, 16, rd, v3, e3, r4);
    chk("postrst_miso2", rd, 16'h0705);

    v0 = n_vld; r0 = n_req; e0 = n_err; cmd0 = cmd;
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b0; MOSI = i[0]; wait_clks(4);
      chk($sformatf("idle_miso%0d", i), MISO, 0);
      SCLK = 1'b1; wait_clks(4);
    end
    wait_clks(6);
    chk("idle_vld", n_vld - v0, 0);
    chk("idle_req", n_req - r0, 0);
    chk("idle_err", n_err - e0, 0);
    chk("idle_cmd", cmd, cmd0);
    spi_frame(16'h0000, 16, rd, v3, e3, r4);
    chk("idle_then_miso", rd, 16'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

SPI responder that models the A2D converter's end of the A2D SPI link. It receives 16-bit command frames from the SPI master, decodes the requested channel, fetches a 12-bit sample through a simple sample port, and returns that sample MSB-first in the next frame. It is used as the converter model in system benches and synthesizes as an FPGA test responder; all logic runs on the fast system clock with synchronized SPI inputs.

## Interface
- FRM_BITS, 16, bits per SPI frame
- SYNC_STAGES, 2, synchronizer depth on SS_n/SCLK/MOSI
- clk  in  1  system clock; SCLK half-period ≥ 4 clk cycles
- rst_n  in  1  reset; asynchronous, active-low
- SS_n  in  1  slave select from master, active-low
- SCLK  in  1  SPI clock from master, idles high
- MOSI  in  1  command data from master
- MISO  out  1  response data to master
- smpl_data  in  12  sample value for smpl_ch, valid combinationally while smpl_req is high
- smpl_req  out  1  one-cycle pulse: capture smpl_data this cycle
- smpl_ch  out  3  channel being sampled
- cmd  out  16  last complete command frame received
- cmd_vld  out  1  one-cycle pulse when cmd updates
- frm_err  out  1  one-cycle pulse when a frame ends with bit count ≠ 16

## Operation
- SS_n, SCLK, MOSI each pass through SYNC_STAGES flops (SS_n and SCLK preset high, MOSI cleared). Edge detect on synced SCLK gives sclk_rise/sclk_fall; SS_n gives ss_fall/ss_rise.
- States: IDLE, SHIFT. IDLE→SHIFT on ss_fall; SHIFT→IDLE on ss_rise.
- On ss_fall: tx_shft ← {4'b0000, result}; bit_cnt ← 0; first_fall ← 1.
- In SHIFT, sclk_rise: rx_shft ← {rx_shft[14:0], MOSI_sync}; bit_cnt increments, saturating at 31.
- In SHIFT, sclk_fall: if first_fall, clear first_fall without shifting; else tx_shft ← {tx_shft[14:0], 1'b0}.
- MISO = tx_shft[15] in SHIFT, 0 in IDLE.
- On ss_rise with bit_cnt == 16: cmd ← rx_shft, cmd_vld pulses; next cycle smpl_req pulses with smpl_ch = rx_shft[13:11]; result ← smpl_data in that cycle.
- On ss_rise with bit_cnt ≠ 16: frm_err pulses; cmd, result, smpl_ch unchanged; no smpl_req.
- Consequently a frame always returns the sample requested by the previous good frame.
- ss_fall while a smpl_req is pending is not possible (master deasserts SS_n ≥ 1 SCLK period); result captured before tx load is used.

## Timing
- Reset values: MISO 0, cmd 0, cmd_vld 0, smpl_req 0, smpl_ch 0, frm_err 0, result 0, state IDLE.
- Input-to-edge latency: SYNC_STAGES+1 clk cycles.
- MISO bit n+1 appears ≤ SYNC_STAGES+2 clk after SCLK fall, before the next SCLK rise given the ≥ 4-clk half-period rule.
- cmd_vld/frm_err: SYNC_STAGES+1 clk after raw SS_n rise; smpl_req 1 clk after cmd_vld.
- Reset mid-frame: immediate return to reset values; the partial frame is dropped; the next frame after reset returns 0x0000.
- SCLK edges while SS_n high: ignored.

## Structure
- Package a2d_pkg: FRM_BITS, channel field positions (CH_MSB = 13, CH_LSB = 11), pad width 4, resp_state_t enum {IDLE, SHIFT}.
- Sub-module spi_sync_edge: parameterized N-stage synchronizer with rise/fall pulse outputs and reset value parameter, instantiated for SS_n and SCLK; MOSI uses the synchronizer only.
- Top holds the FSM, shift registers, bit counter and sample capture.

## Test plan
- Reset, frame cmd 0x2800 (ch 5), smpl_data = 0xABC at smpl_req -> first frame MISO reads 0x0000, cmd_vld with cmd = 0x2800, smpl_ch = 5; second frame MISO reads 0x0ABC.
- Back-to-back frames ch 0, 3, 7 with smpl_data = 0x100*ch+0x5 -> responses 0x0000, 0x0005, 0x0305, 0x0705 on consecutive frames.
- Short frame (10 SCLK pulses) -> frm_err pulse, no cmd_vld/smpl_req, next good frame still returns prior result.
- 17-bit frame -> frm_err, cmd unchanged.
- rst_n low at bit 8 of a frame -> all outputs 0 immediately; following frame returns 0x0000 and decodes its command correctly.
- SCLK toggling with SS_n high -> no state change, MISO stays 0.
